// File: rtl/btn_press_classifier_pkg.sv
// Shared definitions for the button press classifier: event codes and FSM states.
// The event codes are also meant for the menu controller that consumes the events.
package btn_press_classifier_pkg;

  localparam logic [1:0] EV_SHORT        = 2'd0;
  localparam logic [1:0] EV_LONG         = 2'd1;
  localparam logic [1:0] EV_REPEAT       = 2'd2;
  localparam logic [1:0] EV_LONG_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_REPEATING = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_press_classifier.sv
// Classifies a debounced button into SHORT / LONG / REPEAT / LONG_RELEASE events and
// hands them to the consumer through a single-entry valid/ready register.
module btn_press_classifier
  import btn_press_classifier_pkg::*;
#(
  parameter int   CLKIN_FREQ    = 27_000_000,
  parameter real  LONG_PERIOD   = 0.5,
  parameter real  REPEAT_PERIOD = 0.1,
  parameter logic IDLE_STATE    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       debounceIn,
  input  logic       pressEdgeIn,
  output logic       eventValid,
  input  logic       eventReady,
  output logic [1:0] eventCode,
  output logic       eventDropped,
  output logic       btnHeld
);

  localparam int LONG_CYCLES   = int'(real'(CLKIN_FREQ) * LONG_PERIOD);
  localparam int REPEAT_CYCLES = int'(real'(CLKIN_FREQ) * REPEAT_PERIOD);
  localparam int MAX_CYCLES    = max_int(LONG_CYCLES, REPEAT_CYCLES);
  localparam int CW            = $clog2(MAX_CYCLES);

  localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, dropped_q, held_q;
  logic [1:0]    code_q;

  logic          released, press, emit, load;
  logic [1:0]    ev_code;

  assign released = (debounceIn == IDLE_STATE);
  assign press    = (pressEdgeIn == ~IDLE_STATE);

  // Release is checked before the terminal count so it always wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    ev_code = EV_SHORT;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end
      end
      ST_PRESSED: begin
        if (released) begin
          emit    = 1'b1;
          ev_code = EV_SHORT;
          state_d = ST_IDLE;
        end else if (cnt_q == LONG_TC) begin
          emit    = 1'b1;
          ev_code = EV_LONG;
          state_d = ST_REPEATING;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_REPEATING: begin
        if (released) begin
          emit    = 1'b1;
          ev_code = EV_LONG_RELEASE;
          state_d = ST_IDLE;
        end else if (cnt_q == REP_TC) begin
          emit    = 1'b1;
          ev_code = EV_REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A slot is free when empty or being drained this very cycle.
  assign load = emit && (!valid_q || eventReady);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      code_q    <= EV_SHORT;
      dropped_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      held_q    <= (state_d != ST_IDLE);
      dropped_q <= emit && valid_q && !eventReady;
      if (load) begin
        valid_q <= 1'b1;
        code_q  <= ev_code;
      end else if (valid_q && eventReady) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign eventValid   = valid_q;
  assign eventCode    = code_q;
  assign eventDropped = dropped_q;
  assign btnHeld      = held_q;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed bench for btn_press_classifier: 10-cycle LONG, 4-cycle REPEAT, released level 1.
`timescale 1ns/1ps
module tb_btn_press_classifier;
  import btn_press_classifier_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       debounceIn;
  logic       pressEdgeIn;
  logic       eventValid;
  logic       eventReady;
  logic [1:0] eventCode;
  logic       eventDropped;
  logic       btnHeld;

  int errors = 0;
  int checks = 0;

  btn_press_classifier #(
    .CLKIN_FREQ   (1000),
    .LONG_PERIOD  (0.01),
    .REPEAT_PERIOD(0.004),
    .IDLE_STATE   (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .debounceIn  (debounceIn),
    .pressEdgeIn (pressEdgeIn),
    .eventValid  (eventValid),
    .eventReady  (eventReady),
    .eventCode   (eventCode),
    .eventDropped(eventDropped),
    .btnHeld     (btnHeld)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives the level low and a press pulse sampled by the next edge (E0).
  task automatic do_press();
    debounceIn  = 1'b0;
    pressEdgeIn = 1'b0;
    step();
    pressEdgeIn = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; debounceIn = 1'b1; pressEdgeIn = 1'b1; eventReady = 1'b1;
    step(); step();
    checks++;
    if ({eventValid, eventCode, eventDropped, btnHeld} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: got v/c/d/h=%b expected 00000",
               {eventValid, eventCode, eventDropped, btnHeld});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_short();
    logic [4:0] exp;
    do_press();
    for (int k = 1; k <= 4; k++) begin
      if (k == 3) debounceIn = 1'b1;
      step();
      exp = (k == 3) ? {1'b1, EV_SHORT, 1'b0, 1'b0} : {3'b000, 1'b0, (k < 3)};
      checks++;
      if ({eventValid, eventCode, eventDropped, btnHeld} !== exp) begin
        errors++;
        $display("FAIL short k=%0d: got v/c/d/h=%b expected %b", k,
                 {eventValid, eventCode, eventDropped, btnHeld}, exp);
      end
    end
  endtask

  task automatic test_long_repeat();
    logic [4:0] exp;
    do_press();
    for (int k = 1; k <= 26; k++) begin
      if (k == 25) debounceIn = 1'b1;
      step();
      case (k)
        10:           exp = {1'b1, EV_LONG, 1'b0, 1'b1};
        14, 18, 22:   exp = {1'b1, EV_REPEAT, 1'b0, 1'b1};
        25:           exp = {1'b1, EV_LONG_RELEASE, 1'b0, 1'b0};
        default:      exp = {1'b0, 2'b00, 1'b0, (k < 25)};
      endcase
      checks++;
      // Code is don't-care when no event is held.
      if (exp[4] ? ({eventValid, eventCode, eventDropped, btnHeld} !== exp)
                 : ({eventValid, eventDropped, btnHeld} !== {exp[4], exp[1], exp[0]})) begin
        errors++;
        $display("FAIL long_repeat k=%0d: got v/c/d/h=%b expected %b", k,
                 {eventValid, eventCode, eventDropped, btnHeld}, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] exp;
    eventReady = 1'b0;
    do_press();
    for (int k = 1; k <= 20; k++) begin
      step();
      exp = (k >= 10) ? {1'b1, EV_LONG, (k == 14 || k == 18), 1'b1}
                      : {1'b0, 2'b00, 1'b0, 1'b1};
      checks++;
      if (exp[4] ? ({eventValid, eventCode, eventDropped, btnHeld} !== exp)
                 : ({eventValid, eventDropped, btnHeld} !== {exp[4], exp[1], exp[0]})) begin
        errors++;
        $display("FAIL backpressure k=%0d: got v/c/d/h=%b expected %b", k,
                 {eventValid, eventCode, eventDropped, btnHeld}, exp);
      end
    end
    // LONG drains while LONG_RELEASE loads into the same slot.
    eventReady = 1'b1;
    debounceIn = 1'b1;
    step();
    checks++;
    if ({eventValid, eventCode, eventDropped, btnHeld} !== {1'b1, EV_LONG_RELEASE, 2'b00}) begin
      errors++;
      $display("FAIL backpressure_b2b: got v/c/d/h=%b expected 11100",
               {eventValid, eventCode, eventDropped, btnHeld});
    end
    step();
    checks++;
    if (eventValid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_drain: got valid=%b expected 0", eventValid);
    end
  endtask

  task automatic test_release_at_tc();
    do_press();
    for (int k = 1; k <= 15; k++) begin
      if (k == 10) debounceIn = 1'b1;
      step();
      checks++;
      if (k == 10) begin
        if ({eventValid, eventCode, btnHeld} !== {1'b1, EV_SHORT, 1'b0}) begin
          errors++;
          $display("FAIL release_at_tc: got v/c/h=%b expected 1000",
                   {eventValid, eventCode, btnHeld});
        end
      end else if ({eventValid, btnHeld} !== {1'b0, (k < 10)}) begin
        errors++;
        $display("FAIL release_at_tc k=%0d: got v/h=%b expected %b", k,
                 {eventValid, btnHeld}, {1'b0, (k < 10)});
      end
    end
  endtask

  task automatic test_reset_mid_press();
    eventReady = 1'b0;
    do_press();
    debounceIn = 1'b1;
    step();
    checks++;
    if ({eventValid, eventCode} !== {1'b1, EV_SHORT}) begin
      errors++;
      $display("FAIL rst_pending: got v/c=%b expected 100", {eventValid, eventCode});
    end
    do_press();
    for (int k = 1; k <= 5; k++) step();
    reset = 1'b1;
    #1;
    checks++;
    if ({eventValid, eventCode, eventDropped, btnHeld} !== 5'b0) begin
      errors++;
      $display("FAIL rst_async: got v/c/d/h=%b expected 00000",
               {eventValid, eventCode, eventDropped, btnHeld});
    end
    #1 reset = 1'b0;
    eventReady = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      if (k == 15) debounceIn = 1'b1;
      step();
      checks++;
      if ({eventValid, eventDropped, btnHeld} !== 3'b000) begin
        errors++;
        $display("FAIL rst_after k=%0d: got v/d/h=%b expected 000", k,
                 {eventValid, eventDropped, btnHeld});
      end
    end
  endtask

  task automatic test_second_pulse();
    logic [4:0] exp;
    do_press();
    for (int k = 1; k <= 13; k++) begin
      if (k == 3)  pressEdgeIn = 1'b0;
      if (k == 4)  pressEdgeIn = 1'b1;
      if (k == 12) debounceIn = 1'b1;
      step();
      case (k)
        10:      exp = {1'b1, EV_LONG, 1'b0, 1'b1};
        12:      exp = {1'b1, EV_LONG_RELEASE, 1'b0, 1'b0};
        default: exp = {1'b0, 2'b00, 1'b0, (k < 12)};
      endcase
      checks++;
      if (exp[4] ? ({eventValid, eventCode, eventDropped, btnHeld} !== exp)
                 : ({eventValid, eventDropped, btnHeld} !== {exp[4], exp[1], exp[0]})) begin
        errors++;
        $display("FAIL second_pulse k=%0d: got v/c/d/h=%b expected %b", k,
                 {eventValid, eventCode, eventDropped, btnHeld}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long_repeat();
    test_backpressure();
    test_release_at_tc();
    test_reset_mid_press();
    test_second_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
